// File: rtl/frame_pkg.sv
// Shared types and constants for the serial frame transmitter.
package frame_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_MARK  = 3'd2,
        S_D2    = 3'd3,
        S_D1    = 3'd4,
        S_D0    = 3'd5,
        S_PAR   = 3'd6,
        S_GAP   = 3'd7
    } state_t;

    localparam int START_LEN = 1;
    localparam int MARK_LEN  = 1;
    localparam int DATA_BITS = 3;
    localparam int FRAME_HDR = START_LEN + MARK_LEN;

    localparam int GAP_MIN   = 1;
    localparam int GAP_MAX   = 15;
    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/frame_gap_counter.sv
// Loadable down-counter timing the idle guard after each frame.
module frame_gap_counter
    import frame_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 load,
    input  logic [GAP_CNT_W-1:0] load_val,
    input  logic                 dec,
    output logic                 zero
);

    logic [GAP_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/frame_tx.sv
// Serial frame transmitter: START, MARK, 3 data bits MSB first, guard gap.
// Optional even-parity bit after D0 when FRAME_TX_PARITY_EN is defined.
module frame_tx
    import frame_pkg::*;
#(
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset_b,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 x_out,
    output logic                 busy,
    output logic                 done
);

    // Out-of-range settings are clamped so the guard is never zero-length.
    localparam int GAP_LIM = (GAP_CYCLES < GAP_MIN) ? GAP_MIN :
                             (GAP_CYCLES > GAP_MAX) ? GAP_MAX : GAP_CYCLES;
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'(GAP_LIM - 1);

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] data_q;
    logic                 x_nxt;
    logic                 done_nxt;
    logic                 accept;
    logic                 gap_load;
    logic                 gap_dec;
    logic                 gap_zero;

    assign tx_ready = (state == S_IDLE);
    assign busy     = (state != S_IDLE);
    assign accept   = tx_valid && tx_ready;

    frame_gap_counter u_gap (
        .clk      (clk),
        .reset_b  (reset_b),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .dec      (gap_dec),
        .zero     (gap_zero)
    );

    always_ff @(posedge clk) begin
        if (!reset_b) begin
            state  <= S_IDLE;
            x_out  <= 1'b1;
            done   <= 1'b0;
            data_q <= '0;
        end else begin
            state <= state_nxt;
            x_out <= x_nxt;
            done  <= done_nxt;
            if (accept) begin
                data_q <= tx_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        gap_load  = 1'b0;
        gap_dec   = 1'b0;
        unique case (state)
            S_IDLE:  if (tx_valid) state_nxt = S_START;
            S_START: state_nxt = S_MARK;
            S_MARK:  state_nxt = S_D2;
            S_D2:    state_nxt = S_D1;
            S_D1:    state_nxt = S_D0;
`ifdef FRAME_TX_PARITY_EN
            S_D0:    state_nxt = S_PAR;
            S_PAR: begin
                state_nxt = S_GAP;
                gap_load  = 1'b1;
            end
`else
            S_D0: begin
                state_nxt = S_GAP;
                gap_load  = 1'b1;
            end
`endif
            S_GAP: begin
                if (gap_zero) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    gap_dec = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // The line is registered, so it is driven from the state being entered.
    always_comb begin
        x_nxt = 1'b1;
        unique case (state_nxt)
            S_START: x_nxt = 1'b0;
            S_D2:    x_nxt = data_q[2];
            S_D1:    x_nxt = data_q[1];
            S_D0:    x_nxt = data_q[0];
`ifdef FRAME_TX_PARITY_EN
            S_PAR:   x_nxt = ^data_q;
`endif
            default: x_nxt = 1'b1;
        endcase
    end

endmodule

// File: doc/frame_tx.md
FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 SHALL provide parameter GAP_CYCLES, default 1, meaning the number of idle-high guard cycles after each frame (legal range 1..15).
REQ-002 SHALL provide port clk  input  1  rising-edge clock.
REQ-003 SHALL provide port reset_b  input  1  reset, synchronous, active-low.
REQ-004 SHALL provide port tx_valid  input  1  payload offered.
REQ-005 SHALL provide port tx_data  input  3  payload, MSB transmitted first.
REQ-006 SHALL provide port tx_ready  output  1  block can accept a payload.
REQ-007 SHALL provide port x_out  output  1  serial line, idle high, registered.
REQ-008 SHALL provide port busy  output  1  frame or guard in progress.
REQ-009 SHALL provide port done  output  1  one-cycle pulse at frame completion.

Function
REQ-010 SHALL implement states IDLE, START, MARK, D2, D1, D0, PAR (macro only), GAP.
REQ-011 SHALL drive tx_ready=1 only in IDLE, and busy=1 in every other state.
REQ-012 SHALL accept a payload on a rising edge with tx_valid=1 and tx_ready=1, latch tx_data, and enter START on that same edge.
REQ-013 SHALL follow the transition sequence START->MARK->D2->D1->D0->(PAR)->GAP, one cycle per state with no input dependence.
REQ-014 SHALL drive x_out per state: IDLE=1, START=0, MARK=1, Dn=latched bit n, PAR=parity, GAP=1.
REQ-015 SHALL hold GAP for exactly GAP_CYCLES cycles using a down-counter, then return to IDLE.
REQ-016 SHALL assert done for exactly one cycle, namely the first IDLE cycle after GAP.
REQ-017 SHALL ignore tx_valid and tx_data changes while busy; the latched payload is not affected.
REQ-018 SHALL, when tx_valid is held high continuously, accept the next payload in the first IDLE cycle, giving a frame period of 6+GAP_CYCLES cycles (7+GAP_CYCLES with parity).
REQ-019 SHALL handle GAP_CYCLES=1 by spending a single GAP cycle, with no zero-length gap allowed.

Reset
REQ-020 SHALL, while reset_b=0 at a rising edge, set state=IDLE, x_out=1, done=0, busy=0, the latched payload to 0, and the gap counter to 0.
REQ-021 SHALL, on reset mid-frame, abort the frame immediately with x_out=1 from the next edge and no done pulse.
REQ-022 SHALL give tx_ready=1 in the first cycle after reset is released.

Configuration
REQ-023 SHALL, with macro FRAME_TX_PARITY_EN defined, insert the PAR state after D0, driving even parity (XOR of the 3 payload bits).
REQ-024 SHALL, without FRAME_TX_PARITY_EN, go directly from D0 to GAP, with no parity logic compiled in.

Structure
REQ-025 SHALL place the following in shared package frame_pkg:
- state encoding constants;
- frame field lengths (START/MARK = 1, data = 3);
- GAP_CYCLES limits.
REQ-026 SHALL instantiate one sub-module, frame_gap_counter: a loadable 4-bit down-counter with a zero flag.

Verification
REQ-027 SHALL cover: reset_b=0 for 2 cycles mid-frame -> x_out=1, busy=0, tx_ready=1, done=0 the cycle after release.
REQ-028 SHALL cover: tx_data=3'b101 accepted, GAP_CYCLES=1, no parity -> x_out sequence 0,1,1,0,1,1 then done=1 in the next cycle.
REQ-029 SHALL cover: FRAME_TX_PARITY_EN, tx_data=3'b110 -> x_out 0,1,1,1,0,0,1, with PAR=0.
REQ-030 SHALL cover: tx_valid held high, GAP_CYCLES=3, payloads 3'b001 then 3'b111 -> second START exactly 9 cycles after the first START.
REQ-031 SHALL cover: tx_data changed from 3'b010 to 3'b111 during D2 -> transmitted bits remain 0,1,0.
REQ-032 SHALL cover: tx_valid pulsed while busy -> no acceptance, and only one done per accepted payload.
